mem_wb_stage: RTL and testbench

// Memory-access and writeback stage of the 5-stage RV32I pipeline. Accepts one

---
 rtl/mem_wb_stage_if.sv | 22 ++
 rtl/mem_wb_stage.sv | 219 +++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-memory port of the MEM/WB stage: req/gnt request channel plus rvalid read return.
// The stage drives the master side and the data memory drives the slave side.
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// RV32I memory-access / writeback stage: sub-word loads and stores over a req/gnt/rvalid
// port, registered writeback triple, and upstream stall while a memory access is in flight.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           alu_in,
    input  logic [31:0]           DataB_in,
    input  logic [31:0]           pcPlus4_in,
    input  logic [4:0]            AddrD_in,
    input  logic                  RegWEn_in,
    input  logic                  MemRW_in,
    input  logic [1:0]            WBSel_in,
    input  logic [2:0]            funct3_in,
    mem_wb_stage_if.master        dmem,
    output logic                  RegWEn_out,
    output logic [4:0]            AddrD_out,
    output logic [31:0]           DataD_out,
    output logic                  mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // Counter only has to reach TIMEOUT-1; the abort happens on that cycle's edge.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         lane_q, lane_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [4:0]         rd_q, rd_d;
    logic               regwen_q, regwen_d;

    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;

    logic               wb_en_q, wb_en_d;
    logic [4:0]         wb_addr_q, wb_addr_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               err_q, err_d;

    logic               accept, mem_op, f3_ok, aligned, timeout_hit;
    logic [3:0]         be_new;
    logic [31:0]        wdata_new, rd_shift, load_data;

    assign in_ready    = (state_q == IDLE);
    assign accept      = in_valid & in_ready;
    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

    // Legality of the incoming access: funct3 set depends on load vs store, then natural alignment.
    always_comb begin
        mem_op = MemRW_in | (WBSel_in == 2'b00);
        if (MemRW_in)
            f3_ok = funct3_in inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (funct3_in[1:0])
            2'b10:   aligned = (alu_in[1:0] == 2'b00);
            2'b01:   aligned = ~alu_in[0];
            default: aligned = 1'b1;
        endcase
    end

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = DataB_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_new    = 4'b0001 << alu_in[1:0];
                wdata_new = {4{DataB_in[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {alu_in[1], 1'b0};
                wdata_new = {2{DataB_in[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_shift = dmem.dmem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_data = {24'h0, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_data = {16'h0, rd_shift[15:0]};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    // NOTE: every signal gets a hold/idle default before the case so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        regwen_d  = regwen_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!mem_op) begin
                        wb_en_d   = RegWEn_in & (AddrD_in != 5'd0);
                        wb_addr_d = AddrD_in;
                        wb_data_d = (WBSel_in == 2'b10) ? pcPlus4_in : alu_in;
                    end else if (!(f3_ok && aligned)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = REQ;
                        cnt_d    = '0;
                        req_d    = 1'b1;
                        we_d     = MemRW_in;
                        addr_d   = {alu_in[31:2], 2'b00};
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                        lane_d   = alu_in[1:0];
                        funct3_d = funct3_in;
                        rd_d     = AddrD_in;
                        regwen_d = RegWEn_in;
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_gnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? IDLE : WAIT;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (dmem.dmem_rvalid) begin
                    state_d   = IDLE;
                    wb_en_d   = regwen_q & (rd_q != 5'd0);
                    wb_addr_d = rd_q;
                    wb_data_d = load_data;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lane_q    <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            regwen_q  <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            regwen_q  <= regwen_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign RegWEn_out = wb_en_q;
    assign AddrD_out  = wb_addr_q;
    assign DataD_out  = wb_data_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expected writebacks, memory
// requests and error pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_wb_stage;

    typedef enum logic [1:0] {EV_WB, EV_ERR, EV_REQ} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        chk_wdata;
    } ev_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_in;
    logic [31:0] DataB_in;
    logic [31:0] pcPlus4_in;
    logic [4:0]  AddrD_in;
    logic        RegWEn_in;
    logic        MemRW_in;
    logic [1:0]  WBSel_in;
    logic [2:0]  funct3_in;
    logic        RegWEn_out;
    logic [4:0]  AddrD_out;
    logic [31:0] DataD_out;
    logic        mem_err;

    mem_wb_stage_if dmem ();

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_in     (alu_in),
        .DataB_in   (DataB_in),
        .pcPlus4_in (pcPlus4_in),
        .AddrD_in   (AddrD_in),
        .RegWEn_in  (RegWEn_in),
        .MemRW_in   (MemRW_in),
        .WBSel_in   (WBSel_in),
        .funct3_in  (funct3_in),
        .dmem       (dmem),
        .RegWEn_out (RegWEn_out),
        .AddrD_out  (AddrD_out),
        .DataD_out  (DataD_out),
        .mem_err    (mem_err)
    );

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input logic [4:0] rd, input logic [31:0] data);
        ev_t e;
        e = '{EV_WB, rd, data, 1'b0, 32'h0, 4'h0, 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        ev_t e;
        e = '{EV_ERR, 5'd0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic exp_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic chk);
        ev_t e;
        e = '{EV_REQ, 5'd0, wdata, we, addr, be, chk};
        exp_q.push_back(e);
    endtask

    // Monitor: one popped expectation per observed DUT event.
    always @(negedge clk) begin
        if (reset_n) begin
            if (RegWEn_out) begin
                if (exp_q.size() == 0) check("unexpected_wb", {27'h0, AddrD_out}, 32'h0);
                else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("wb_kind", 32'(EV_WB), 32'(e.kind));
                    check("wb_addr", {27'h0, AddrD_out}, {27'h0, e.rd});
                    check("wb_data", DataD_out, e.data);
                end
            end
            if (mem_err) begin
                if (exp_q.size() == 0) check("unexpected_err", 32'h1, 32'h0);
                else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("err_kind", 32'(EV_ERR), 32'(e.kind));
                end
            end
            if (dmem.dmem_req && dmem.dmem_gnt) begin
                if (exp_q.size() == 0) check("unexpected_req", dmem.dmem_addr, 32'h0);
                else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("req_kind", 32'(EV_REQ), 32'(e.kind));
                    check("req_we", {31'h0, dmem.dmem_we}, {31'h0, e.we});
                    check("req_addr", dmem.dmem_addr, e.addr);
                    check("req_be", {28'h0, dmem.dmem_be}, {28'h0, e.be});
                    if (e.chk_wdata) check("req_wdata", dmem.dmem_wdata, e.data);
                end
            end
        end
    end

    // Presents one instruction until accepted, then scrambles the fields to prove they were captured.
    task automatic drive_op(input logic [31:0] alu, input logic [31:0] b, input logic [31:0] pc4,
                            input logic [4:0] rd, input logic regwen, input logic memrw,
                            input logic [1:0] wbsel, input logic [2:0] f3);
        int n;
        alu_in = alu; DataB_in = b; pcPlus4_in = pc4; AddrD_in = rd;
        RegWEn_in = regwen; MemRW_in = memrw; WBSel_in = wbsel; funct3_in = f3;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        alu_in     = $urandom;
        DataB_in   = $urandom;
        pcPlus4_in = $urandom;
        AddrD_in   = 5'($urandom);
        funct3_in  = 3'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_load(input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
        for (int i = 0; i < gnt_wait; i++) begin
            check("req_stall_ready", {31'h0, in_ready}, 32'h0);
            check("req_held", {31'h0, dmem.dmem_req}, 32'h1);
            step();
        end
        dmem.dmem_gnt = 1'b1;
        step();
        dmem.dmem_gnt = 1'b0;
        for (int i = 0; i < rv_wait; i++) begin
            check("wait_stall_ready", {31'h0, in_ready}, 32'h0);
            check("wait_req_low", {31'h0, dmem.dmem_req}, 32'h0);
            step();
        end
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = rdata;
        step();
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = $urandom;
        check("load_done_ready", {31'h0, in_ready}, 32'h1);
    endtask

    task automatic mem_store(input int gnt_wait);
        for (int i = 0; i < gnt_wait; i++) begin
            check("store_stall_ready", {31'h0, in_ready}, 32'h0);
            step();
        end
        dmem.dmem_gnt = 1'b1;
        step();
        dmem.dmem_gnt = 1'b0;
        check("store_done_ready", {31'h0, in_ready}, 32'h1);
        check("store_req_low", {31'h0, dmem.dmem_req}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; alu_in = '0; DataB_in = '0; pcPlus4_in = '0; AddrD_in = '0;
        RegWEn_in = 1'b0; MemRW_in = 1'b0; WBSel_in = 2'b01; funct3_in = '0;
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;

        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_req", {31'h0, dmem.dmem_req}, 32'h0);
        check("rst_regwen", {31'h0, RegWEn_out}, 32'h0);
        check("rst_datad", DataD_out, 32'h0);
        check("rst_mem_err", {31'h0, mem_err}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Non-memory ops back to back, one per cycle.
        exp_wb(5'd5, 32'h0000_1234);
        drive_op(32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01, 3'b000);
        drive_op(32'h1234, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 2'b01, 3'b000);
        check("rd0_no_wb", {31'h0, RegWEn_out}, 32'h0);
        exp_wb(5'd1, 32'h0000_4008);
        drive_op(32'hdead, 32'h0, 32'h4008, 5'd1, 1'b1, 1'b0, 2'b10, 3'b000);
        exp_wb(5'd31, 32'h0000_0077);
        drive_op(32'h77, 32'h0, 32'h0, 5'd31, 1'b1, 1'b0, 2'b11, 3'b000);
        drive_op(32'h99, 32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 2'b01, 3'b000);
        check("regwen0_no_wb", {31'h0, RegWEn_out}, 32'h0);
        step();
        check("idle_regwen", {31'h0, RegWEn_out}, 32'h0);
        check("idle_data_hold", DataD_out, 32'h99);

        // Loads: byte/half sign and zero extension; gnt/rvalid on the last allowed cycle.
        exp_req(1'b0, 32'h100, 4'b1000, 32'h0, 1'b0);
        exp_wb(5'd10, 32'hFFFF_FF80);
        drive_op(32'h103, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 2'b00, 3'b000);
        mem_load(2, 2, 32'h80FF_0000);

        exp_req(1'b0, 32'h100, 4'b1000, 32'h0, 1'b0);
        exp_wb(5'd11, 32'h0000_0080);
        drive_op(32'h103, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 2'b00, 3'b100);
        mem_load(2, 2, 32'h80FF_0000);

        exp_req(1'b0, 32'h104, 4'b1100, 32'h0, 1'b0);
        exp_wb(5'd12, 32'hFFFF_8001);
        drive_op(32'h106, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 2'b00, 3'b001);
        mem_load(0, 0, 32'h8001_7FFE);

        exp_req(1'b0, 32'h104, 4'b0011, 32'h0, 1'b0);
        exp_wb(5'd13, 32'h0000_ABCD);
        drive_op(32'h104, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0, 2'b00, 3'b101);
        mem_load(1, 1, 32'h1234_ABCD);

        exp_req(1'b0, 32'h108, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd14, 32'hDEAD_BEEF);
        drive_op(32'h108, 32'h0, 32'h0, 5'd14, 1'b1, 1'b0, 2'b00, 3'b010);
        mem_load(3, 3, 32'hDEAD_BEEF);

        // Stores: lane replication and byte enables, no writeback.
        exp_req(1'b1, 32'h200, 4'b1100, 32'h1234_1234, 1'b1);
        drive_op(32'h202, 32'hABCD_1234, 32'h0, 5'd9, 1'b0, 1'b1, 2'b01, 3'b001);
        mem_store(1);
        exp_req(1'b1, 32'h300, 4'b0010, 32'h5555_5555, 1'b1);
        drive_op(32'h301, 32'h0000_0055, 32'h0, 5'd9, 1'b0, 1'b1, 2'b01, 3'b000);
        mem_store(0);
        exp_req(1'b1, 32'h400, 4'b1111, 32'hCAFE_BABE, 1'b1);
        drive_op(32'h400, 32'hCAFE_BABE, 32'h0, 5'd9, 1'b0, 1'b1, 2'b01, 3'b010);
        mem_store(3);

        // Misaligned and illegal accesses: error pulse, no request.
        exp_err();
        drive_op(32'h102, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 2'b00, 3'b010);
        for (int i = 0; i < 2; i++) begin
            check("misalign_no_req", {31'h0, dmem.dmem_req}, 32'h0);
            check("misalign_ready", {31'h0, in_ready}, 32'h1);
            step();
        end
        exp_err();
        drive_op(32'h201, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 2'b01, 3'b001);
        exp_err();
        drive_op(32'h200, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 2'b01, 3'b100);
        exp_err();
        drive_op(32'h200, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 2'b00, 3'b011);
        step();
        check("illegal_no_req", {31'h0, dmem.dmem_req}, 32'h0);

        // Timeout with gnt never arriving: request held exactly TIMEOUT cycles.
        exp_err();
        drive_op(32'h500, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 2'b00, 3'b010);
        for (int i = 0; i < 4; i++) begin
            check("to_req_high", {31'h0, dmem.dmem_req}, 32'h1);
            step();
        end
        check("to_req_dropped", {31'h0, dmem.dmem_req}, 32'h0);
        check("to_ready", {31'h0, in_ready}, 32'h1);
        step();

        // Timeout with rvalid never arriving.
        exp_req(1'b0, 32'h600, 4'b1111, 32'h0, 1'b0);
        exp_err();
        drive_op(32'h600, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 2'b00, 3'b010);
        dmem.dmem_gnt = 1'b1;
        step();
        dmem.dmem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_wait_stall", {31'h0, in_ready}, 32'h0);
            step();
        end
        check("to_wait_ready", {31'h0, in_ready}, 32'h1);
        step();

        // Reset while waiting for read data; late rvalid must be ignored.
        exp_req(1'b0, 32'h700, 4'b1111, 32'h0, 1'b0);
        drive_op(32'h700, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 2'b00, 3'b010);
        dmem.dmem_gnt = 1'b1;
        step();
        dmem.dmem_gnt = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_ready", {31'h0, in_ready}, 32'h1);
        check("arst_addr", dmem.dmem_addr, 32'h0);
        check("arst_be", {28'h0, dmem.dmem_be}, 32'h0);
        check("arst_we", {31'h0, dmem.dmem_we}, 32'h0);
        check("arst_datad", DataD_out, 32'h0);
        check("arst_addrd", {27'h0, AddrD_out}, 32'h0);
        step();
        reset_n = 1'b1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'h1111_1111;
        step();
        dmem.dmem_rvalid = 1'b0;
        step();
        check("late_rvalid_regwen", {31'h0, RegWEn_out}, 32'h0);
        check("late_rvalid_data", DataD_out, 32'h0);

        exp_wb(5'd2, 32'h0000_0ABC);
        drive_op(32'hABC, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 2'b01, 3'b000);
        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
